rc_filter_mc: RTL

- Multi-channel, runtime-programmable first-order RC (single-pole IIR) low-pass filter for ADC sample streams.
- Optional second cascaded pole per channel.
- Adds over the fixed single-channel filter: a valid strobe, a glitch-free coefficient update, a bypass mode, a synchronous clear, first-sample preload and rounded/saturated output.
- Sits between the ADC capture registers and the data splitter/AXIS packers; all channels are processed in parallel and share one coefficient.

---
 rtl/rc_filter_mc.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/rc_filter_mc.sv
// rc_filter_mc
//   Multi-channel, runtime-programmable single-pole IIR (RC) low-pass filter
//   with an optional second cascaded pole per channel. All channels run in
//   parallel and share one coefficient, alpha = coef / 2^FRAC.
//
//   Pipeline (one sample per cycle, fixed 4-edge latency):
//     edge k   : register sample (x_r), latch coef_active
//     edge k+1 : update pole P1
//     edge k+2 : update pole P2, capture rounded P1 output
//     edge k+3 : select and register out_data, out_valid = 1
//
// Ports
//   clk        : clock
//   reset      : asynchronous, active-low reset
//   in_valid   : qualifies in_data
//   in_data    : packed signed samples, channel c at [c*ADC_WIDTH +: ADC_WIDTH]
//   coef_in    : new coefficient (unsigned)
//   coef_we    : write strobe for coef_in into the shadow register
//   order      : 0 = one pole, 1 = two cascaded poles
//   bypass     : 1 = output the delayed raw input
//   clear      : synchronous clear of all filter state and pipeline valids
//   out_valid  : one-cycle strobe per filtered sample
//   out_data   : packed signed results, same packing as in_data
module rc_filter_mc #(
    parameter int ADC_WIDTH  = 14,
    parameter int CHANNELS   = 2,
    parameter int FRAC       = 32,
    parameter int COEF_WIDTH = 16,
    parameter int A_DEFAULT  = 343
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [CHANNELS*ADC_WIDTH-1:0] in_data,
    input  logic [COEF_WIDTH-1:0]         coef_in,
    input  logic                          coef_we,
    input  logic                          order,
    input  logic                          bypass,
    input  logic                          clear,
    output logic                          out_valid,
    output logic [CHANNELS*ADC_WIDTH-1:0] out_data
);

    localparam int ACC_W = ADC_WIDTH + FRAC + 1;
    // One extra bit so the full-precision product always fits before it is
    // added to the accumulator (COEF_WIDTH may equal FRAC).
    localparam int EXT_W = ACC_W + 1;

    localparam logic [COEF_WIDTH-1:0]       COEF_RST = COEF_WIDTH'(A_DEFAULT);
    localparam logic signed [ACC_W:0]       HALF     = (ACC_W+1)'(1) <<< (FRAC-1);
    localparam logic signed [ADC_WIDTH+1:0] Y_MAX    = (ADC_WIDTH+2)'((1 << (ADC_WIDTH-1)) - 1);

    typedef logic signed [ADC_WIDTH-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]     acc_t;

    // Next accumulator value of one pole. An unprimed pole preloads with the
    // input so a small alpha does not produce a long start-up ramp.
    function automatic acc_t pole_next(input acc_t acc, input sample_t x,
                                       input logic [COEF_WIDTH-1:0] coef,
                                       input logic primed);
        acc_t                      pre;
        logic signed [ADC_WIDTH:0] fb;
        logic signed [ADC_WIDTH:0] diff;
        logic signed [EXT_W-1:0]   prod;
        logic signed [EXT_W-1:0]   sum;
        pre  = {{(ACC_W-ADC_WIDTH){x[ADC_WIDTH-1]}}, x};
        fb   = (ADC_WIDTH+1)'(acc >>> FRAC);          // floor of the integer part
        diff = {x[ADC_WIDTH-1], x} - fb;
        // Both operands are extended to EXT_W, so the low EXT_W bits of the
        // unsigned product equal the signed product (coef is zero-extended).
        prod = {{(EXT_W-ADC_WIDTH-1){diff[ADC_WIDTH]}}, diff}
             * {{(EXT_W-COEF_WIDTH){1'b0}}, coef};
        sum  = {acc[ACC_W-1], acc} + prod;
        return primed ? acc_t'(sum) : (pre <<< FRAC);
    endfunction

    // Round half up to an integer sample; only positive overflow can occur.
    function automatic sample_t round_sat(input acc_t acc);
        logic signed [ACC_W:0]       biased;
        logic signed [ADC_WIDTH+1:0] r;
        biased = {acc[ACC_W-1], acc} + HALF;
        r      = (ADC_WIDTH+2)'(biased >>> FRAC);
        if (r > Y_MAX) begin
            r = Y_MAX;
        end
        return sample_t'(r);
    endfunction

    logic                  v1, v2, v3;
    logic                  primed1, primed2;
    logic [COEF_WIDTH-1:0] coef_shadow, coef_active, coef_p2;

    sample_t x_r  [CHANNELS];
    sample_t x_d1 [CHANNELS];
    sample_t x_d2 [CHANNELS];
    sample_t y1_d [CHANNELS];
    acc_t    acc1 [CHANNELS];
    acc_t    acc2 [CHANNELS];

    sample_t                       in_samp  [CHANNELS];
    sample_t                       y1       [CHANNELS];
    sample_t                       y2       [CHANNELS];
    acc_t                          acc1_nxt [CHANNELS];
    acc_t                          acc2_nxt [CHANNELS];
    logic [CHANNELS*ADC_WIDTH-1:0] out_nxt;

    // Coefficient path. coef_active is reloaded only on accepted samples, so
    // every channel switches on the same sample; a write arriving together
    // with a sample lands in the shadow after the active copy took the old
    // value. coef_p2 travels with the sample into the second pole so both
    // poles of one sample use the same coefficient.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of its neighbours.
        if (!reset) begin
            coef_shadow <= COEF_RST;
            coef_active <= COEF_RST;
            coef_p2     <= COEF_RST;
        end else begin
            if (coef_we) begin
                coef_shadow <= coef_in;
            end
            if (in_valid && !clear) begin
                coef_active <= coef_shadow;
            end
            if (v1 && !clear) begin
                coef_p2 <= coef_active;
            end
        end
    end

    // Pipeline valids and the shared primed flags; clear has top priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            primed1   <= 1'b0;
            primed2   <= 1'b0;
        end else if (clear) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
            primed1   <= 1'b0;
            primed2   <= 1'b0;
        end else begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
            if (v1) begin
                primed1 <= 1'b1;
            end
            if (v2) begin
                primed2 <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a value on every path (default
        // first, then full per-channel assignment), so no latch is inferred.
        out_nxt = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            in_samp[c]  = in_data[c*ADC_WIDTH +: ADC_WIDTH];
            y1[c]       = round_sat(acc1[c]);
            y2[c]       = round_sat(acc2[c]);
            acc1_nxt[c] = pole_next(acc1[c], x_r[c], coef_active, primed1);
            // P2 consumes the rounded P1 output of the same sample, which is
            // what acc1 holds one edge after the P1 update.
            acc2_nxt[c] = pole_next(acc2[c], y1[c], coef_p2, primed2);
            if (bypass) begin
                out_nxt[c*ADC_WIDTH +: ADC_WIDTH] = x_d2[c];
            end else if (order) begin
                out_nxt[c*ADC_WIDTH +: ADC_WIDTH] = y2[c];
            end else begin
                out_nxt[c*ADC_WIDTH +: ADC_WIDTH] = y1_d[c];
            end
        end
    end

    // Per-channel data path. Filter state keeps updating in bypass mode so
    // leaving bypass continues from an unbroken state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the accumulator arrays are architectural state and must
            // start at zero; the sample pipeline is reset as well so out_data
            // never carries undefined values after reset.
            for (int c = 0; c < CHANNELS; c++) begin
                x_r[c]  <= '0;
                x_d1[c] <= '0;
                x_d2[c] <= '0;
                y1_d[c] <= '0;
                acc1[c] <= '0;
                acc2[c] <= '0;
            end
            out_data <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (clear) begin
                    acc1[c] <= '0;
                    acc2[c] <= '0;
                end else begin
                    if (in_valid) begin
                        x_r[c] <= in_samp[c];
                    end
                    if (v1) begin
                        acc1[c] <= acc1_nxt[c];
                        x_d1[c] <= x_r[c];
                    end
                    if (v2) begin
                        acc2[c] <= acc2_nxt[c];
                        x_d2[c] <= x_d1[c];
                        y1_d[c] <= y1[c];
                    end
                end
            end
            // out_data holds between strobes, including across a clear.
            if (v3 && !clear) begin
                out_data <= out_nxt;
            end
        end
    end

endmodule
